// File: rtl/kvadd_tutorial_example_pkg.sv
// Shared types for the kvadd AXI memory responder.
// Channel state encodings and beat-counter width.
package kvadd_tutorial_example_pkg;

  localparam int BEAT_W = 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/kvadd_tutorial_example_bram_dp.sv
// Simple dual-port RAM: port A byte-enabled write, port B
// registered read-first read. Array contents are never reset.
module kvadd_tutorial_example_bram_dp #(
  parameter int DW    = 512,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW/8-1:0] i_a_be,
  input  logic [DW-1:0]   i_a_wdata,
  input  logic            i_b_re,
  input  logic [AW-1:0]   i_b_addr,
  output logic [DW-1:0]   o_b_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_a_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_a_be[b]) begin
          r_mem[i_a_addr][b*8 +: 8] <= i_a_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Output register only: gives a defined rdata out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_b_re) begin
      r_rdata <= r_mem[i_b_addr];
    end
  end

  assign o_b_rdata = r_rdata;

endmodule

// File: rtl/kvadd_tutorial_example_axi_mem_responder.sv
// AXI4 slave memory responder: independent single-outstanding
// INCR read and write bursts served from an internal RAM.
module kvadd_tutorial_example_axi_mem_responder
  import kvadd_tutorial_example_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_WORDS  = 1024
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast,
  output logic [31:0]                     stat_rd_bursts,
  output logic [31:0]                     stat_wr_bursts
);

  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int OFF   = $clog2(DW/8);
  localparam int IDX_W = $clog2(C_MEM_DEPTH_WORDS);

  localparam logic [IDX_W-1:0]  IDX_ONE  = 1;
  localparam logic [BEAT_W-1:0] BEAT_ONE = 1;
  localparam logic [31:0]       STAT_ONE = 1;

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_rstate, w_rstate_nxt;

  logic              r_awready, r_wready, r_bvalid;
  logic              r_arready, r_rvalid, r_rlast;
  logic [IDX_W-1:0]  r_widx, r_ridx;
  logic [BEAT_W-1:0] r_wlen, r_wcnt;
  logic [BEAT_W-1:0] r_rlen, r_rcnt;
  logic              r_err;
  logic [31:0]       r_stat_wr, r_stat_rd;

  logic              w_aw_hs, w_w_hs, w_b_hs;
  logic              w_ar_hs, w_r_hs;
  logic [IDX_W-1:0]  w_aw_idx, w_ar_idx;
  logic              w_wlast_bad;
  logic              w_we, w_re;
  logic [IDX_W-1:0]  w_raddr;
  logic              w_unused;

  assign w_aw_hs = s_axi_awvalid & r_awready;
  assign w_w_hs  = s_axi_wvalid & r_wready;
  assign w_b_hs  = r_bvalid & s_axi_bready;
  assign w_ar_hs = s_axi_arvalid & r_arready;
  assign w_r_hs  = r_rvalid & s_axi_rready;

  // Low offset bits and bits above the depth are ignored.
  assign w_aw_idx = s_axi_awaddr[OFF +: IDX_W];
  assign w_ar_idx = s_axi_araddr[OFF +: IDX_W];
  assign w_unused = ^{s_axi_awaddr, s_axi_araddr};

  assign w_wlast_bad = s_axi_wlast ^ (r_wcnt == r_wlen);

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_we         = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        if (w_w_hs) begin
          w_we = 1'b1;
          if (r_wcnt == r_wlen) w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (w_b_hs) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so
  // they stay low while reset is held.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_err     <= 1'b0;
      r_stat_wr <= '0;
    end else begin
      if (w_aw_hs) begin
        r_widx <= w_aw_idx;
        r_wlen <= s_axi_awlen;
        r_wcnt <= '0;
      end
      if (w_w_hs) begin
        r_widx <= r_widx + IDX_ONE;
        r_wcnt <= r_wcnt + BEAT_ONE;
        if (w_wlast_bad) r_err <= 1'b1;
      end
      if (w_b_hs) r_stat_wr <= r_stat_wr + STAT_ONE;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_re         = 1'b0;
    w_raddr      = r_ridx;
    unique case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_DATA;
          w_re         = 1'b1;
          w_raddr      = w_ar_idx;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          if (r_rlast) begin
            w_rstate_nxt = R_IDLE;
          end else begin
            w_re    = 1'b1;
            w_raddr = r_ridx + IDX_ONE;
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rlast   <= 1'b0;
      r_stat_rd <= '0;
    end else if (w_ar_hs) begin
      r_ridx  <= w_ar_idx;
      r_rlen  <= s_axi_arlen;
      r_rcnt  <= '0;
      r_rlast <= (s_axi_arlen == 8'd0);
    end else if (w_r_hs) begin
      if (r_rlast) begin
        r_rlast   <= 1'b0;
        r_stat_rd <= r_stat_rd + STAT_ONE;
      end else begin
        r_ridx  <= r_ridx + IDX_ONE;
        r_rcnt  <= r_rcnt + BEAT_ONE;
        r_rlast <= ((r_rcnt + BEAT_ONE) == r_rlen);
      end
    end
  end

  kvadd_tutorial_example_bram_dp #(
    .DW    (DW),
    .DEPTH (C_MEM_DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_ram (
    .clk       (aclk),
    .rst       (areset),
    .i_a_we    (w_we),
    .i_a_addr  (r_widx),
    .i_a_be    (s_axi_wstrb),
    .i_a_wdata (s_axi_wdata),
    .i_b_re    (w_re),
    .i_b_addr  (w_raddr),
    .o_b_rdata (s_axi_rdata)
  );

  assign s_axi_awready  = r_awready;
  assign s_axi_wready   = r_wready;
  assign s_axi_bvalid   = r_bvalid;
  assign s_axi_arready  = r_arready;
  assign s_axi_rvalid   = r_rvalid;
  assign s_axi_rlast    = r_rlast;
  assign err_wlast      = r_err;
  assign stat_rd_bursts = r_stat_rd;
  assign stat_wr_bursts = r_stat_wr;

endmodule

// File: doc/kvadd_tutorial_example_axi_mem_responder.md
Name: kvadd_tutorial_example_axi_mem_responder

Overview:
- AXI4 slave memory responder: the target end of the kernel's AXI4 master port.
- Services the read master's AR/R bursts and the write master's AW/W/B bursts from an internal byte-writable RAM.
- Used as the memory model in kernel-level simulation and as an on-chip scratch target.
- Read and write channels run independently, each with one outstanding burst.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, address width of AR/AW.
- C_M_AXI_DATA_WIDTH, 512, data width; must be a power of 2, at least 32.
- C_MEM_DEPTH_WORDS, 1024, RAM depth in data words; must be a power of 2.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awvalid / s_axi_awready  in / out  1 / 1  write address handshake.
- s_axi_awaddr  in  C_M_AXI_ADDR_WIDTH  burst byte address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_wvalid / s_axi_wready  in / out  1 / 1  write data handshake.
- s_axi_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid / s_axi_bready  out / in  1 / 1  write response (always OKAY).
- s_axi_arvalid / s_axi_arready  in / out  1 / 1  read address handshake.
- s_axi_araddr  in  C_M_AXI_ADDR_WIDTH  burst byte address.
- s_axi_arlen  in  8  beats minus 1.
- s_axi_rvalid / s_axi_rready  out / in  1 / 1  read data handshake.
- s_axi_rdata  out  C_M_AXI_DATA_WIDTH  read data.
- s_axi_rlast  out  1  last read beat.
- err_wlast  out  1  sticky: wlast disagreed with awlen.
- stat_rd_bursts  out  32  completed read bursts (wraps).
- stat_wr_bursts  out  32  completed write bursts (wraps).

Behaviour:
- Reset (async assert, sync-deasserted use): outputs are
  - all valid/ready outputs = 0;
  - rdata = 0, rlast = 0;
  - err_wlast = 0, counters = 0.
  - RAM contents are not reset.
- Word index = (addr >> log2(DW/8)) mod C_MEM_DEPTH_WORDS.
  - Unaligned low bits are ignored.
  - Index wraps at depth; beat addresses increment and wrap the same way.
  - INCR bursts only; 4 KB crossing is not checked.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid, latch index and awlen, clear beat count, go W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes the RAM under wstrb (byte granular) and increments index and count.
  - If wlast is asserted with count != awlen, or wlast is absent when count == awlen: set err_wlast.
  - Leave W_DATA when count == awlen (awlen governs; wlast is advisory).
  - W_RESP: bvalid=1, held until bready. Then stat_wr_bursts++ and return to W_IDLE.
  - awready=0 outside W_IDLE.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid, latch awlen-equivalent (arlen) and index, register rdata <= mem[index], rlast = (arlen==0), go R_DATA.
  - AR-accept to first rvalid: 1 cycle.
  - R_DATA: rvalid=1. rdata and rlast are stable while rready=0.
  - On rready with !rlast: rdata <= mem[index+1], count++, rlast = (count+1 == arlen). This gives one beat per cycle with continuous rready.
  - On rready with rlast: rvalid=0, stat_rd_bursts++, return to R_IDLE. arready returns the following cycle.
- Simultaneous read and write to the same word in the same cycle: read returns the old data (read-first).
- AR and AW accepted in the same cycle are both taken; the channels are fully independent.
- err_wlast clears only on reset.
- Reset mid-burst: both FSMs return to IDLE and the partial burst is abandoned. No B or R beats follow.

Decomposition:
- Shared package kvadd_tutorial_example_pkg holds:
  - state enums wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_DATA};
  - beat-count width constant (8).
- Sub-module kvadd_tutorial_example_bram_dp:
  - simple dual-port RAM, one clock;
  - port A write with byte enables;
  - port B registered read, read-first;
  - parameterised by data width and depth.

Test Plan:
- Write then read back: AW addr 0x0, awlen 3, wdata k*0x11 with all strobes; then AR addr 0x0, arlen 3 -> 4 R beats 0x00, 0x11, 0x22, 0x33; rlast on beat 4 only; one B response; both stat counters = 1.
- Byte strobes: preload word 5 with all 0xFF, write wstrb=0x0000_0000_0000_000F with wdata 0 -> readback has low 4 bytes 0x00, rest 0xFF.
- Read backpressure: arlen 7, rready toggles 1,0,0,1… -> rdata and rlast stable during stalls; exactly 8 beats, in order, no drops.
- Wrap-around: depth 1024, DW 512, write burst at addr 1023*64 with awlen 1 -> second beat lands in word 0, verified by read at addr 0.
- Protocol error: awlen 3 with wlast on beat 2 -> err_wlast=1 stays set, 4 beats still accepted, one B; a clean burst afterward leaves err_wlast at 1.
- Reset mid-read: assert areset during beat 3 of an arlen 15 burst -> rvalid=0 immediately, arready=1 after release, a new burst returns correct data.
